msb_sign_inverter: RTL and testbench

//  Operand-preparation stage for the iterative divider. Registers two 32-bit operands.
//  For signed operations it forms each operand's magnitude by two's-complement negation.
//  It finds each magnitude's most-significant set bit and derives the divisor
//  pre-alignment shift and the result-sign flags.

---
 rtl/div_pkg.sv | 12 +
 rtl/msb_priority_encoder.sv | 20 ++
 rtl/msb_sign_inverter.sv | 91 +++++++++
 tb/tb_msb_sign_inverter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared divider constants and helpers, used by operand preparation and the result stage.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_IDX_W = $clog2(DIV_WIDTH);

  // Two's-complement negation modulo 2^DIV_WIDTH; the most negative value maps to itself.
  function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] x);
    return ~x + DIV_WIDTH'(1);
  endfunction

endpackage

// File: rtl/msb_priority_encoder.sv
// Combinational index of the highest set bit; an all-zero input yields index 0.
module msb_priority_encoder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    index = '0;
    // Ascending scan, so the last hit is the most significant one.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/msb_sign_inverter.sv
// Divider operand preparation: magnitudes, MSB indices, pre-alignment shift and result signs,
// all registered with a fixed one-cycle latency.
module msb_sign_inverter
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 sign,
  input  logic [DIV_WIDTH-1:0] src_a,
  input  logic [DIV_WIDTH-1:0] src_b,
  output logic                 valid_out,
  output logic [DIV_WIDTH-1:0] neg_a,
  output logic [DIV_WIDTH-1:0] neg_b,
  output logic [DIV_WIDTH-1:0] abs_a,
  output logic [DIV_WIDTH-1:0] abs_b,
  output logic [DIV_IDX_W-1:0] msb_a,
  output logic [DIV_IDX_W-1:0] msb_b,
  output logic [DIV_IDX_W-1:0] shift_amt,
  output logic                 quot_neg,
  output logic                 rem_neg,
  output logic                 b_zero
);

  localparam int unsigned WIDTH = DIV_WIDTH;
  localparam int unsigned IDX_W = DIV_IDX_W;

  logic [WIDTH-1:0] neg_a_d, neg_b_d, abs_a_d, abs_b_d;
  logic [IDX_W-1:0] msb_a_d, msb_b_d, shift_amt_d;
  logic             quot_neg_d, rem_neg_d, b_zero_d;

  always_comb begin
    neg_a_d    = negate(src_a);
    neg_b_d    = negate(src_b);
    abs_a_d    = (sign && src_a[WIDTH-1]) ? neg_a_d : src_a;
    abs_b_d    = (sign && src_b[WIDTH-1]) ? neg_b_d : src_b;
    quot_neg_d = sign & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
    rem_neg_d  = sign & src_a[WIDTH-1];
    b_zero_d   = (src_b == '0);
  end

  msb_priority_encoder #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_msb_a (
    .value (abs_a_d),
    .index (msb_a_d)
  );

  msb_priority_encoder #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_msb_b (
    .value (abs_b_d),
    .index (msb_b_d)
  );

  // Saturate at zero when the divisor is already wider than the dividend.
  always_comb begin
    shift_amt_d = (msb_a_d >= msb_b_d) ? (msb_a_d - msb_b_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      neg_a     <= '0;
      neg_b     <= '0;
      abs_a     <= '0;
      abs_b     <= '0;
      msb_a     <= '0;
      msb_b     <= '0;
      shift_amt <= '0;
      quot_neg  <= 1'b0;
      rem_neg   <= 1'b0;
      b_zero    <= 1'b0;
    end else begin
      valid_out <= valid_in;
      neg_a     <= neg_a_d;
      neg_b     <= neg_b_d;
      abs_a     <= abs_a_d;
      abs_b     <= abs_b_d;
      msb_a     <= msb_a_d;
      msb_b     <= msb_b_d;
      shift_amt <= shift_amt_d;
      quot_neg  <= quot_neg_d;
      rem_neg   <= rem_neg_d;
      b_zero    <= b_zero_d;
    end
  end

endmodule

// File: tb/tb_msb_sign_inverter.sv
// Scoreboard bench: each driven cycle queues its hand-computed registered response,
// a monitor pops and compares one record per cycle.
module tb_msb_sign_inverter;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        sign;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        valid_out;
  logic [31:0] neg_a, neg_b, abs_a, abs_b;
  logic [4:0]  msb_a, msb_b, shift_amt;
  logic        quot_neg, rem_neg, b_zero;

  typedef struct packed {
    logic        valid;
    logic [31:0] neg_a;
    logic [31:0] neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [4:0]  msb_a;
    logic [4:0]  msb_b;
    logic [4:0]  shift;
    logic        qn;
    logic        rn;
    logic        bz;
  } resp_t;

  resp_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string names[$];

  msb_sign_inverter dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .sign      (sign),
    .src_a     (src_a),
    .src_b     (src_b),
    .valid_out (valid_out),
    .neg_a     (neg_a),
    .neg_b     (neg_b),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .msb_a     (msb_a),
    .msb_b     (msb_b),
    .shift_amt (shift_amt),
    .quot_neg  (quot_neg),
    .rem_neg   (rem_neg),
    .b_zero    (b_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic resp_t mk(input logic v, input logic [31:0] na, input logic [31:0] nb,
                               input logic [31:0] aa, input logic [31:0] ab,
                               input logic [4:0] ma, input logic [4:0] mb, input logic [4:0] sh,
                               input logic qn, input logic rn, input logic bz);
    resp_t r;
    r.valid = v;  r.neg_a = na; r.neg_b = nb; r.abs_a = aa; r.abs_b = ab;
    r.msb_a = ma; r.msb_b = mb; r.shift = sh; r.qn = qn;    r.rn = rn;    r.bz = bz;
    return r;
  endfunction

  // Drive one cycle; queue the response expected after the capturing edge.
  task automatic drive(input string nm, input logic r, input logic v, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input resp_t e);
    @(negedge clk);
    reset = r; valid_in = v; sign = s; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    names.push_back(nm);
  endtask

  // Monitor: one registered response per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      resp_t e, act;
      string nm;
      e  = exp_q.pop_front();
      nm = names.pop_front();
      act = mk(valid_out, neg_a, neg_b, abs_a, abs_b, msb_a, msb_b, shift_amt,
               quot_neg, rem_neg, b_zero);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got v=%b na=%h nb=%h aa=%h ab=%h ma=%0d mb=%0d sh=%0d qn=%b rn=%b bz=%b, want v=%b na=%h nb=%h aa=%h ab=%h ma=%0d mb=%0d sh=%0d qn=%b rn=%b bz=%b",
                 nm, act.valid, act.neg_a, act.neg_b, act.abs_a, act.abs_b, act.msb_a,
                 act.msb_b, act.shift, act.qn, act.rn, act.bz, e.valid, e.neg_a, e.neg_b,
                 e.abs_a, e.abs_b, e.msb_a, e.msb_b, e.shift, e.qn, e.rn, e.bz);
      end
    end
  end

  resp_t zero;

  initial begin
    reset = 1'b1; valid_in = 1'b0; sign = 1'b0; src_a = '0; src_b = '0;
    zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    drive("reset_0", 1, 1, 1, 32'h1234_5678, 32'h0000_0005, zero);
    drive("reset_1", 1, 1, 1, 32'hFFFF_FFF9, 32'h8000_0000, zero);
    // Data registers load even with valid_in low; b=0 raises b_zero.
    drive("idle", 0, 0, 0, 32'h0, 32'h0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    drive("s_neg7_div2", 0, 1, 1, 32'hFFFF_FFF9, 32'h0000_0002,
          mk(1, 32'h7, 32'hFFFF_FFFE, 32'h7, 32'h2, 2, 1, 1, 1, 1, 0));
    drive("u_big", 0, 1, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFE,
          mk(1, 32'h7, 32'h2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 31, 31, 0, 0, 0, 0));
    drive("s_minint_div0", 0, 1, 1, 32'h8000_0000, 32'h0,
          mk(1, 32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0, 31, 0, 31, 1, 1, 1));
    drive("u_shift_sat", 0, 1, 0, 32'h3, 32'h100,
          mk(1, 32'hFFFF_FFFD, 32'hFFFF_FF00, 32'h3, 32'h100, 1, 8, 0, 0, 0, 0));
    drive("u_shift_7", 0, 1, 0, 32'h100, 32'h3,
          mk(1, 32'hFFFF_FF00, 32'hFFFF_FFFD, 32'h100, 32'h3, 8, 1, 7, 0, 0, 0));
    drive("s_both_neg", 0, 1, 1, 32'hFFFF_FF9C, 32'hFFFF_FFFD,
          mk(1, 32'h64, 32'h3, 32'h64, 32'h3, 6, 1, 5, 0, 1, 0));
    drive("s_pos_div_m1", 0, 1, 1, 32'h5, 32'hFFFF_FFFF,
          mk(1, 32'hFFFF_FFFB, 32'h1, 32'h5, 32'h1, 2, 0, 2, 1, 0, 0));
    // Back-to-back stream with reset landing on the middle beat.
    drive("stream_1", 0, 1, 1, 32'h0000_1000, 32'h0000_0010,
          mk(1, 32'hFFFF_F000, 32'hFFFF_FFF0, 32'h1000, 32'h10, 12, 4, 8, 0, 0, 0));
    drive("stream_2_reset", 1, 1, 1, 32'hFFFF_FFF0, 32'h7, zero);
    drive("stream_3", 0, 1, 0, 32'h7FFF_FFFF, 32'h1,
          mk(1, 32'h8000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1, 30, 0, 30, 0, 0, 0));
    drive("tail_idle", 0, 0, 1, 32'h1, 32'h1,
          mk(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d responses pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
